// File: rtl/scan_mux.sv
// scan_mux: N-channel registered channel multiplexer with manual select,
// round-robin auto-scan (dwell + enable mask) and hold modes.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   mode     00 manual, 01 auto-scan, 10/11 hold
//   sel_in   manual channel index (out-of-range values are ignored)
//   dwell    auto-scan dwell; each channel is held for dwell+1 cycles
//   en_mask  auto-scan channel enable mask, bit i = channel i
//   din      flattened channel inputs, channel i at din[i*W +: W]
//   dout     registered selected data
//   sel_out  registered current channel index
//   chg      one-cycle pulse: sel_out changed on this edge
//   wrap     one-cycle pulse: auto-scan advance wrapped to a lower/equal index
module scan_mux #(
    parameter int W       = 32,
    parameter int NCH     = 8,
    parameter int DWELL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [$clog2(NCH)-1:0] sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic [NCH-1:0]        en_mask,
    input  logic [NCH*W-1:0]      din,
    output logic [W-1:0]          dout,
    output logic [$clog2(NCH)-1:0] sel_out,
    output logic                  chg,
    output logic                  wrap
);

    localparam int SELW = $clog2(NCH);

    // Channel count widened by one bit so the range check also works
    // when NCH is a power of two.
    localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    logic [W-1:0]       chan [NCH];
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SELW-1:0]    nsel;
    logic               wrap_nxt;
    logic               in_range;
    logic               adv_found;
    logic [SELW-1:0]    adv_sel;
    logic [SELW-1:0]    probe;
    int                 step;

    // Unflatten the input bus into an indexable channel array.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chan[i] = din[i*W +: W];
    end

    assign in_range = ({1'b0, sel_in} < NCH_L);

    // Round-robin search: first enabled channel after sel_out, wrapping
    // modulo NCH and ending on sel_out itself. With nothing enabled the
    // current selection is kept and adv_found stays low.
    always_comb begin
        adv_found = 1'b0;
        adv_sel   = sel_out;
        step      = 0;
        probe     = '0;
        for (int k = 1; k <= NCH; k++) begin
            step = int'(sel_out) + k;
            if (step >= NCH) begin
                step = step - NCH;
            end
            probe = SELW'(step);
            if (!adv_found && en_mask[probe]) begin
                adv_found = 1'b1;
                adv_sel   = probe;
            end
        end
    end

    // Next selection, dwell counter and wrap flag.
    always_comb begin
        nsel     = sel_out;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                if (in_range) begin
                    nsel = sel_in;
                end
                cnt_nxt = '0;
            end
            MODE_AUTO: begin
                // >= so that lowering dwell below cnt forces an advance.
                if (cnt < dwell) begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end else begin
                    cnt_nxt  = '0;
                    nsel     = adv_sel;
                    wrap_nxt = adv_found && (adv_sel <= sel_out);
                end
            end
            default: begin
                // Hold: selection and counter frozen, data keeps tracking.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_out <= '0;
            dout    <= '0;
            chg     <= 1'b0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else begin
            sel_out <= nsel;
            dout    <= chan[nsel];
            chg     <= (nsel != sel_out);
            wrap    <= wrap_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Testbench for scan_mux: directed vectors with hand-computed expectations,
// checked by a scoreboard queue popped by an independent monitor.
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   mode8, mode5;
    logic [2:0]   sel_in8, sel_in5;
    logic [15:0]  dwell8, dwell5;
    logic [7:0]   en8;
    logic [4:0]   en5;
    logic [255:0] din8;
    logic [159:0] din5;
    logic [31:0]  dout8, dout5;
    logic [2:0]   sel8, sel5;
    logic         chg8, wrap8, chg5, wrap5;

    scan_mux #(.W(32), .NCH(8), .DWELL_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel_in(sel_in8),
        .dwell(dwell8), .en_mask(en8), .din(din8),
        .dout(dout8), .sel_out(sel8), .chg(chg8), .wrap(wrap8)
    );

    scan_mux #(.W(32), .NCH(5), .DWELL_W(16)) u5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel_in(sel_in5),
        .dwell(dwell5), .en_mask(en5), .din(din5),
        .dout(dout5), .sel_out(sel5), .chg(chg5), .wrap(wrap5)
    );

    typedef struct {
        string       tag;
        bit          d5;
        logic [2:0]  sel;
        logic [31:0] dout;
        bit          chg;
        bit          wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    event achk;

    task automatic check_one();
        exp_t        e;
        logic [2:0]  s;
        logic [31:0] d;
        logic        c, w;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        s = e.d5 ? sel5  : sel8;
        d = e.d5 ? dout5 : dout8;
        c = e.d5 ? chg5  : chg8;
        w = e.d5 ? wrap5 : wrap8;
        total++;
        if (s !== e.sel || d !== e.dout || c !== e.chg || w !== e.wrap) begin
            bad++;
            $display("FAIL %s: got sel=%0d dout=%h chg=%b wrap=%b, want sel=%0d dout=%h chg=%b wrap=%b",
                     e.tag, s, d, c, w, e.sel, e.dout, e.chg, e.wrap);
        end
    endtask

    // Monitor: one expectation per clock, plus asynchronous-reset probes.
    always @(posedge clk) begin
        #1;
        check_one();
    end

    always @(achk) begin
        #1;
        check_one();
    end

    task automatic push(input string tag, input bit d5, input int sel,
                        input logic [31:0] dv, input bit c, input bit w);
        exp_t e;
        e.tag  = tag;
        e.d5   = d5;
        e.sel  = 3'(sel);
        e.dout = dv;
        e.chg  = c;
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic cyc(input string tag, input bit d5, input int sel,
                       input logic [31:0] dv, input bit c, input bit w);
        push(tag, d5, sel, dv, c, w);
        @(negedge clk);
    endtask

    function automatic logic [31:0] a8(input int i);
        return 32'hA0 + 32'(i);
    endfunction

    function automatic logic [31:0] b5(input int i);
        return 32'hB0 + 32'(i);
    endfunction

    initial begin
        rst_n   = 1'b0;
        mode8   = 2'b00;
        mode5   = 2'b10;
        sel_in8 = 3'd0;
        sel_in5 = 3'd0;
        dwell8  = 16'd0;
        dwell5  = 16'd0;
        en8     = 8'hFF;
        en5     = 5'h1F;
        for (int i = 0; i < 8; i++) din8[i*32 +: 32] = a8(i);
        for (int i = 0; i < 5; i++) din5[i*32 +: 32] = b5(i);

        // Reset with nonzero inputs
        cyc("rst8", 0, 0, 32'h0, 0, 0);
        cyc("rst5", 1, 0, 32'h0, 0, 0);
        rst_n = 1'b1;

        // Manual select
        cyc("man0", 0, 0, a8(0), 0, 0);
        sel_in8 = 3'd5;
        cyc("man5", 0, 5, a8(5), 1, 0);
        cyc("man5_hold", 0, 5, a8(5), 0, 0);
        cyc("man5_hold", 0, 5, a8(5), 0, 0);
        sel_in8 = 3'd2;
        cyc("man2", 0, 2, a8(2), 1, 0);
        sel_in8 = 3'd0;
        cyc("man0b", 0, 0, a8(0), 1, 0);

        // Auto full scan, dwell=3, all enabled: two laps
        mode8  = 2'b01;
        dwell8 = 16'd3;
        en8    = 8'hFF;
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 0; i < 8; i++) begin
                for (int c = 0; c < 3; c++) cyc("scan_stay", 0, i, a8(i), 0, 0);
                cyc("scan_adv", 0, (i + 1) % 8, a8((i + 1) % 8), 1, (i == 7));
            end
        end

        // Mask skip: channels 2 and 7, dwell=1
        en8    = 8'b1000_0100;
        dwell8 = 16'd1;
        cyc("skip_stay0", 0, 0, a8(0), 0, 0);
        cyc("skip_to2", 0, 2, a8(2), 1, 0);
        for (int r = 0; r < 3; r++) begin
            cyc("skip_stay2", 0, 2, a8(2), 0, 0);
            cyc("skip_to7", 0, 7, a8(7), 1, 0);
            cyc("skip_stay7", 0, 7, a8(7), 0, 0);
            cyc("skip_wrap2", 0, 2, a8(2), 1, 1);
        end

        // Hold freezes selection and counter, data keeps tracking
        en8    = 8'hFF;
        dwell8 = 16'd3;
        cyc("pre_hold", 0, 2, a8(2), 0, 0);
        cyc("pre_hold", 0, 2, a8(2), 0, 0);
        mode8 = 2'b10;
        for (int k = 0; k < 10; k++) begin
            din8[2*32 +: 32] = 32'h1000 + 32'(k);
            cyc("hold", 0, 2, 32'h1000 + 32'(k), 0, 0);
        end
        din8[2*32 +: 32] = a8(2);
        mode8 = 2'b01;
        cyc("resume_stay", 0, 2, a8(2), 0, 0);
        cyc("resume_adv", 0, 3, a8(3), 1, 0);

        // Lowering dwell below cnt forces an advance
        cyc("dw_stay", 0, 3, a8(3), 0, 0);
        cyc("dw_stay", 0, 3, a8(3), 0, 0);
        dwell8 = 16'd1;
        cyc("dw_lower", 0, 4, a8(4), 1, 0);

        // dwell=0 advances every cycle
        dwell8 = 16'd0;
        cyc("dw0", 0, 5, a8(5), 1, 0);
        cyc("dw0", 0, 6, a8(6), 1, 0);
        cyc("dw0", 0, 7, a8(7), 1, 0);
        cyc("dw0_wrap", 0, 0, a8(0), 1, 1);
        cyc("dw0", 0, 1, a8(1), 1, 0);

        // Empty mask: no movement
        en8 = 8'h00;
        for (int k = 0; k < 3; k++) cyc("mask0", 0, 1, a8(1), 0, 0);

        // Only current channel enabled: wrap without change
        en8 = 8'h02;
        cyc("self_only", 0, 1, a8(1), 0, 1);
        cyc("self_only", 0, 1, a8(1), 0, 1);

        // Current channel disabled: left only at dwell expiry
        en8    = 8'h10;
        dwell8 = 16'd2;
        cyc("dis_stay", 0, 1, a8(1), 0, 0);
        cyc("dis_stay", 0, 1, a8(1), 0, 0);
        cyc("dis_adv", 0, 4, a8(4), 1, 0);

        // Auto -> manual on the first edge
        mode8   = 2'b00;
        sel_in8 = 3'd6;
        cyc("to_manual", 0, 6, a8(6), 1, 0);

        // Asynchronous reset mid-scan
        mode8  = 2'b01;
        dwell8 = 16'd3;
        en8    = 8'hFF;
        cyc("pre_arst", 0, 6, a8(6), 0, 0);
        cyc("pre_arst", 0, 6, a8(6), 0, 0);
        #2;
        push("arst_async", 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        -> achk;
        #1;
        cyc("arst_held", 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) cyc("post_rst", 0, 0, a8(0), 0, 0);
        cyc("post_rst_adv", 0, 1, a8(1), 1, 0);

        // NCH=5 instance
        mode8   = 2'b10;
        mode5   = 2'b00;
        sel_in5 = 3'd3;
        cyc("n5_man3", 1, 3, b5(3), 1, 0);
        sel_in5 = 3'd6;
        cyc("n5_oor6", 1, 3, b5(3), 0, 0);
        sel_in5 = 3'd7;
        cyc("n5_oor7", 1, 3, b5(3), 0, 0);
        sel_in5 = 3'd0;
        cyc("n5_man0", 1, 0, b5(0), 1, 0);
        mode5  = 2'b01;
        dwell5 = 16'd0;
        en5    = 5'h1F;
        cyc("n5_scan", 1, 1, b5(1), 1, 0);
        cyc("n5_scan", 1, 2, b5(2), 1, 0);
        cyc("n5_scan", 1, 3, b5(3), 1, 0);
        cyc("n5_scan", 1, 4, b5(4), 1, 0);
        cyc("n5_wrap", 1, 0, b5(0), 1, 1);
        cyc("n5_scan", 1, 1, b5(1), 1, 0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit registered channel multiplexer with three selection modes: manual select, automatic round-robin scan with programmable dwell and channel-enable mask, and hold. It generalises the fixed 8-to-1 32-bit combinational mux. It serves display scanning, debug-bus probing, and multi-source readback on the Nexys4 utility layer. Output data and output index are registered together, so they are always mutually consistent.

## Interface
- `W`, default 32: data width per channel.
- `NCH`, default 8: channel count, minimum 2; need not be a power of two.
- `DWELL_W`, default 16: width of the dwell counter and of the `dwell` input.
- `SELW` is a derived localparam, equal to `$clog2(NCH)`. It is not overridable.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  selection mode: 00 = manual, 01 = auto-scan, 10 = hold, 11 = hold.
- `sel_in`  in  SELW  manual channel index.
- `dwell`  in  DWELL_W  auto-scan dwell; each channel is held for `dwell+1` cycles.
- `en_mask`  in  NCH  auto-scan enable mask; bit i=1 means channel i is included in the scan.
- `din`  in  NCH*W  flattened inputs; channel i occupies `din[i*W +: W]`.
- `dout`  out  W  registered selected data.
- `sel_out`  out  SELW  registered current channel index.
- `chg`  out  1  one-cycle pulse: `sel_out` changed on this edge.
- `wrap`  out  1  one-cycle pulse: auto-scan advance wrapped through index NCH-1 to a lower or equal index.

## Operation
- Reset, asynchronous on `rst_n`=0: `sel_out`=0, `dout`=0, `chg`=0, `wrap`=0, dwell counter `cnt`=0.
- Every edge out of reset:
  - Compute `nsel`.
  - `sel_out` <= `nsel`.
  - `dout` <= `din[nsel*W +: W]`.
  - `chg` <= (`nsel` != `sel_out`).
- Manual (00):
  - `nsel` = `sel_in` if `sel_in` < NCH.
  - Otherwise `nsel` = `sel_out`: an out-of-range index is ignored and the current selection is kept.
  - `cnt` <= 0.
  - `wrap` <= 0.
- Auto (01), while `cnt` < `dwell`:
  - `cnt` <= `cnt`+1.
  - `nsel` = `sel_out`.
- Auto (01), when `cnt` >= `dwell`:
  - `cnt` <= 0.
  - `nsel` = first index j with `en_mask[j]`=1, searching `sel_out`+1 upward, modulo NCH, ending with `sel_out` itself.
  - `wrap` <= 1 if an enabled j was found and j <= `sel_out`; otherwise 0.
  - Using `>=` means a `dwell` lowered below the current `cnt` forces an advance on the next edge.
- Auto with `en_mask`=0: `nsel` = `sel_out`, `chg`=0, `wrap`=0, `cnt` still counts and reloads.
- Auto with only the current channel enabled: the advance returns `sel_out`, so `chg`=0 and `wrap`=1.
- Auto with the current channel disabled: it is left at the next dwell expiry. No early exit.
- Hold (10/11):
  - `nsel` = `sel_out`.
  - `cnt` is frozen.
  - `wrap`=0.
  - `dout` keeps tracking live `din[sel_out]`.
- Mode transitions:
  - Manual→auto: starts from `sel_out` with a full dwell, because manual mode cleared `cnt`.
  - Hold→auto: resumes the frozen `cnt`.
  - Auto→manual: takes effect on the first edge.

## Timing
- Data latency: 1 cycle. `dout` at edge k+1 equals the value of `din[sel_out]` sampled at edge k+1.
- Manual select latency: `sel_in` stable before edge k means `sel_out`/`dout` switch at edge k. `chg` is high for the cycle after edge k.
- Auto dwell: each visited channel occupies exactly `dwell+1` cycles, provided `dwell` and `mode` are constant.
- `chg` and `wrap` are registered, aligned with the `sel_out` update they describe, and never high for two consecutive cycles unless `dwell`=0.
- `dwell`=0: the scan advances every cycle. `chg` is then continuously high whenever two or more channels are enabled.
- Reset asserted mid-scan: all outputs clear immediately, without waiting for `clk`. The first edge after release behaves as from the reset state.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n`=0 with `din` nonzero → `dout`=0, `sel_out`=0, `chg`=`wrap`=0. Assert `rst_n` mid-auto-scan → outputs clear before the next edge.
- Manual: NCH=8, W=32, `din[i]`=0xA0+i, `sel_in`=5 → one cycle later `dout`=0xA5, `sel_out`=5, single `chg` pulse. Then `sel_in`=5 held → no further `chg`.
- Auto full scan: `dwell`=3, `en_mask`=0xFF, start from index 0 →
  - index steps 0→1→…→7→0, exactly 4 cycles per index;
  - `wrap` pulses exactly once, on the 7→0 step;
  - 8 `chg` pulses per lap.
- Auto mask skip: `en_mask`=0b1000_0100, `dwell`=1, start from index 0 → sequence 2,7,2,7 every 2 cycles; `wrap` pulses on each 7→2 step.
- Hold and edge masks:
  - Auto, then `mode`=10 for 10 cycles → `sel_out` frozen, `dout` follows `din` changes.
  - Return to auto → remaining dwell completes.
  - `en_mask`=0 → `sel_out` constant, no `chg`.
- Non-power-of-two: NCH=5, manual `sel_in`=6 → ignored, `sel_out` unchanged. Auto scan with all enabled → sequence 0..4, `wrap` pulses on the 4→0 step.
